// File: rtl/rv32i_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// rv32i_ctrl_fsm
//
// Multi-cycle RV32I control unit. Steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the ALU operation,
// datapath selects, register-file/PC strobes and the imem/dmem handshakes.
// Branches resolve in EXEC from the ALU zero flag (zero=1: branch taken).
//
// Latency, counted from the first imem_req cycle with ready answered at once:
// branch/fence 3, ALU/store/jump 4, load 5 clocks.
//
// Parameters
//   ILLEGAL_HALTS  1: an illegal encoding parks the FSM in TRAP (illegal=1)
//                  0: an illegal encoding retires as a NOP (PC+4)
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active low
//   instr          instruction register contents (valid from DECODE onward)
//   imem_ready     instruction word available (sampled while imem_req=1)
//   dmem_ready     data access complete (sampled while dmem_req=1)
//   zero           ALU flag: branch condition true / result zero
//   imem_req       instruction fetch request
//   ir_write       latch instr from imem, 1-cycle strobe
//   dmem_req       data memory request
//   dmem_we        1 = store
//   dmem_size      00 byte, 01 half, 10 word (funct3[1:0])
//   dmem_unsigned  funct3[2] (LBU/LHU)
//   ALU_op         ALU operation code; ADD whenever not in EXEC
//   alu_src_a      00 rs1, 01 PC, 10 constant 0
//   alu_src_b      0 rs2, 1 immediate
//   alu_reg_en     capture ALU result into the ALU-out register
//   reg_write      register-file write strobe
//   wb_sel         00 ALU-out, 01 load data, 10 PC+4
//   pc_write       PC update strobe, exactly once per retired instruction
//   pc_src         00 PC+4, 01 PC+imm, 10 ALU-out
//   halt           ECALL/EBREAK reached, sticky until reset
//   illegal        illegal encoding trapped, sticky until reset
// -----------------------------------------------------------------------------
module rv32i_ctrl_fsm #(
    parameter int ILLEGAL_HALTS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic        dmem_unsigned,
    output logic [4:0]  ALU_op,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic        alu_reg_en,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        halt,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R  = 4'd0,
        C_ALU_I  = 4'd1,
        C_LUI    = 4'd2,
        C_AUIPC  = 4'd3,
        C_LOAD   = 4'd4,
        C_STORE  = 4'd5,
        C_JAL    = 4'd6,
        C_JALR   = 4'd7,
        C_BRANCH = 4'd8,
        C_NOP    = 4'd9,
        C_SYS    = 4'd10,
        C_ILL    = 4'd11
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_BEQ  = 5'b00000;
    localparam logic [4:0] ALU_BNE  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00011;
    localparam logic [4:0] ALU_BGE  = 5'b00100;
    localparam logic [4:0] ALU_BLT  = 5'b00101;
    localparam logic [4:0] ALU_BGEU = 5'b00110;
    localparam logic [4:0] ALU_BLTU = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_XOR  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01011;
    localparam logic [4:0] ALU_AND  = 5'b01100;
    localparam logic [4:0] ALU_SLL  = 5'b01110;
    localparam logic [4:0] ALU_SRL  = 5'b01111;
    localparam logic [4:0] ALU_SRA  = 5'b10000;

    // Full legality check: unsupported funct3/funct7 combinations and
    // CSR-type SYSTEM encodings are all reported as illegal.
    function automatic cls_t classify(input logic [31:0] ir);
        logic [2:0] f3;
        logic [6:0] f7;
        cls_t       c;
        f3 = ir[14:12];
        f7 = ir[31:25];
        c  = C_ILL;
        case (ir[6:0])
            OP_R: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    c = C_ALU_R;
            end
            OP_IMM: begin
                if (f3 == 3'b001) begin
                    if (f7 == 7'b0000000) c = C_ALU_I;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000 || f7 == 7'b0100000) c = C_ALU_I;
                end else begin
                    c = C_ALU_I;
                end
            end
            OP_LUI:    c = C_LUI;
            OP_AUIPC:  c = C_AUIPC;
            OP_JAL:    c = C_JAL;
            OP_JALR:   if (f3 == 3'b000) c = C_JALR;
            OP_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) c = C_BRANCH;
            OP_LOAD:   if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) c = C_LOAD;
            OP_STORE:  if (f3 <= 3'b010) c = C_STORE;
            OP_FENCE:  if (f3 == 3'b000 || f3 == 3'b001) c = C_NOP;
            // Only ECALL (all zero) and EBREAK (imm=1) are accepted.
            OP_SYSTEM: if (ir[31:7] == 25'h0000000 || ir[31:7] == 25'h0002000) c = C_SYS;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    // alt selects SUB over ADD (funct3 000) and SRA over SRL (funct3 101).
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] branch_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_BEQ;
            3'b001:  op = ALU_BNE;
            3'b100:  op = ALU_BLT;
            3'b101:  op = ALU_BGE;
            3'b110:  op = ALU_BLTU;
            default: op = ALU_BGEU;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] exec_op(input cls_t c, input logic [31:0] ir);
        logic [4:0] op;
        case (c)
            C_ALU_R:  op = arith_op(ir[14:12], ir[30]);
            // ADDI has no SUB form; only the shift-right encoding uses bit 30.
            C_ALU_I:  op = arith_op(ir[14:12], (ir[14:12] == 3'b101) && ir[30]);
            C_BRANCH: op = branch_op(ir[14:12]);
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t     state;
    cls_t       cls_r;
    logic [2:0] f3_r;
    logic       rd_zero_r;
    logic       pc_write_r;
    logic [1:0] pc_src_r;
    logic       br_exec_r;

    cls_t       dec_cls;
    logic [4:0] dec_op;
    logic [1:0] dec_src_a;
    logic       dec_src_b;
    logic       is_jump;

    always_comb begin
        dec_cls   = classify(instr);
        dec_op    = exec_op(dec_cls, instr);
        dec_src_a = 2'b00;
        dec_src_b = 1'b0;
        case (dec_cls)
            C_LUI:   begin dec_src_a = 2'b10; dec_src_b = 1'b1; end
            C_AUIPC: begin dec_src_a = 2'b01; dec_src_b = 1'b1; end
            C_JAL:   begin dec_src_a = 2'b01; dec_src_b = 1'b1; end
            C_ALU_I, C_LOAD, C_STORE, C_JALR: dec_src_b = 1'b1;
            default: ;
        endcase
    end

    assign is_jump = (cls_r == C_JAL) || (cls_r == C_JALR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            cls_r         <= C_NOP;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_size     <= 2'b00;
            dmem_unsigned <= 1'b0;
            ALU_op        <= ALU_ADD;
            alu_src_a     <= 2'b00;
            alu_src_b     <= 1'b0;
            alu_reg_en    <= 1'b0;
            reg_write     <= 1'b0;
            wb_sel        <= 2'b00;
            pc_write_r    <= 1'b0;
            pc_src_r      <= 2'b00;
            br_exec_r     <= 1'b0;
            halt          <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            // Single-cycle strobes and EXEC-only selects fall back each cycle
            ALU_op     <= ALU_ADD;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 1'b0;
            alu_reg_en <= 1'b0;
            reg_write  <= 1'b0;
            wb_sel     <= 2'b00;
            pc_write_r <= 1'b0;
            pc_src_r   <= 2'b00;
            br_exec_r  <= 1'b0;

            case (state)
                S_FETCH: begin
                    // Out of reset the request rises one cycle late so that
                    // every output reads 0 in the reset state itself.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    cls_r     <= dec_cls;
                    f3_r      <= instr[14:12];
                    rd_zero_r <= (instr[11:7] == 5'd0);
                    if (dec_cls == C_SYS) begin
                        halt  <= 1'b1;
                        state <= S_TRAP;
                    end else if (dec_cls == C_ILL && ILLEGAL_HALTS != 0) begin
                        illegal <= 1'b1;
                        state   <= S_TRAP;
                    end else if (dec_cls == C_ILL) begin
                        cls_r      <= C_NOP;
                        alu_reg_en <= 1'b1;
                        pc_write_r <= 1'b1;
                        state      <= S_EXEC;
                    end else begin
                        ALU_op     <= dec_op;
                        alu_src_a  <= dec_src_a;
                        alu_src_b  <= dec_src_b;
                        alu_reg_en <= 1'b1;
                        // Branch and fence retire in EXEC itself.
                        pc_write_r <= (dec_cls == C_BRANCH) || (dec_cls == C_NOP);
                        br_exec_r  <= (dec_cls == C_BRANCH);
                        state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (cls_r)
                        C_BRANCH, C_NOP: begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        C_LOAD, C_STORE: begin
                            dmem_req      <= 1'b1;
                            dmem_we       <= (cls_r == C_STORE);
                            dmem_size     <= f3_r[1:0];
                            dmem_unsigned <= f3_r[2];
                            state         <= S_MEM;
                        end
                        default: begin
                            reg_write  <= !rd_zero_r;
                            pc_write_r <= 1'b1;
                            wb_sel     <= is_jump ? 2'b10 : 2'b00;
                            pc_src_r   <= is_jump ? 2'b10 : 2'b00;
                            state      <= S_WB;
                        end
                    endcase
                end

                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        dmem_size     <= 2'b00;
                        dmem_unsigned <= 1'b0;
                        if (cls_r == C_STORE) begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            reg_write  <= !rd_zero_r;
                            pc_write_r <= 1'b1;
                            wb_sel     <= 2'b01;
                            state      <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end

                default: begin
                    // TRAP: parked until reset, all strobes held low
                    state <= S_TRAP;
                end
            endcase
        end
    end

    // The handshake-completion strobes follow ready in the same cycle; both
    // are masked while reset is asserted so an aborted access never retires.
    assign ir_write = rst_n && (state == S_FETCH) && imem_req && imem_ready;
    assign pc_write = rst_n && (pc_write_r ||
                      ((state == S_MEM) && dmem_req && dmem_ready && (cls_r == C_STORE)));
    assign pc_src   = br_exec_r ? {1'b0, zero} : pc_src_r;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
module tb_rv32i_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        imem_req, ir_write, dmem_req, dmem_we, dmem_unsigned;
    logic [1:0]  dmem_size, alu_src_a, wb_sel, pc_src;
    logic [4:0]  ALU_op;
    logic        alu_src_b, alu_reg_en, reg_write, pc_write, halt, illegal;

    rv32i_ctrl_fsm #(.ILLEGAL_HALTS(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_unsigned(dmem_unsigned),
        .ALU_op(ALU_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_reg_en(alu_reg_en), .reg_write(reg_write), .wb_sel(wb_sel),
        .pc_write(pc_write), .pc_src(pc_src), .halt(halt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          idly;   // imem wait cycles before ready
        int          ddly;   // dmem wait cycles before ready
        logic [4:0]  op;     // ALU_op in EXEC
        logic [1:0]  sa;
        logic        sb;
        int          cyc;    // first imem_req cycle .. pc_write cycle
        int          rw;     // reg_write cycles
        logic [1:0]  wb;     // wb_sel at pc_write
        logic [1:0]  ps;     // pc_src at pc_write
        int          dreq;   // dmem_req cycles
        logic        we;
        logic [1:0]  sz;
        logic        uns;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    vec_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v, e;
        int cyc = 0, iwait = 0, dwait = 0, irw = 0, rw = 0, dreq = 0, aen = 0;
        int bad_alu = 0, ovl = 0;
        int op = 0, sa = 0, sb = 0, wb = 0, ps = 0, we = 0, sz = 0, uns = 0;
        bit started = 0, done = 0;
        v = vecs[idx];
        instr = v.instr;
        zero  = v.zero;
        sb_q.push_back(v);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            imem_ready = imem_req && (iwait >= v.idly);
            dmem_ready = dmem_req && (dwait >= v.ddly);
            #1;
            if (imem_req) begin started = 1; iwait++; end
            if (dmem_req) begin
                dreq++; dwait++;
                we = dmem_we; sz = dmem_size; uns = dmem_unsigned;
            end
            if (started) cyc++;
            if (ir_write) irw++;
            if (reg_write) rw++;
            if (ir_write && pc_write) ovl++;
            if (alu_reg_en) begin
                aen++; op = ALU_op; sa = alu_src_a; sb = alu_src_b;
            end else if (ALU_op != 5'b00010) begin
                bad_alu++;
            end
            if (pc_write) begin done = 1; wb = wb_sel; ps = pc_src; end
        end
        e = sb_q.pop_front();
        chk($sformatf("v%0d retire", idx), done, 1);
        chk($sformatf("v%0d cycles", idx), cyc, e.cyc);
        chk($sformatf("v%0d alu_op", idx), op, e.op);
        chk($sformatf("v%0d src_a", idx), sa, e.sa);
        chk($sformatf("v%0d src_b", idx), sb, e.sb);
        chk($sformatf("v%0d reg_write_cycles", idx), rw, e.rw);
        chk($sformatf("v%0d wb_sel", idx), wb, e.wb);
        chk($sformatf("v%0d pc_src", idx), ps, e.ps);
        chk($sformatf("v%0d dmem_req_cycles", idx), dreq, e.dreq);
        chk($sformatf("v%0d dmem_we", idx), we, e.we);
        chk($sformatf("v%0d dmem_size", idx), sz, e.sz);
        chk($sformatf("v%0d dmem_unsigned", idx), uns, e.uns);
        chk($sformatf("v%0d ir_write_cycles", idx), irw, 1);
        chk($sformatf("v%0d alu_reg_en_cycles", idx), aen, 1);
        chk($sformatf("v%0d alu_op_not_add_outside_exec", idx), bad_alu, 0);
        chk($sformatf("v%0d ir_pc_overlap", idx), ovl, 0);
    endtask

    // Answers the fetch handshake for the current instr; bounded.
    task automatic fetch_once(input string nm);
        bit got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (ir_write) got = 1;
        end
        chk({nm, " fetched"}, got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   got;
        int   req_seen, pcw_seen;

        //             instr         z  id dd op        sa    sb cyc rw wb     ps     dq we sz     uns
        vecs[0]  = '{32'h002081B3, 0, 0, 0, 5'b00010, 2'b00, 0, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // ADD
        vecs[1]  = '{32'h402081B3, 0, 0, 0, 5'b00011, 2'b00, 0, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // SUB
        vecs[2]  = '{32'h407352B3, 0, 0, 0, 5'b10000, 2'b00, 0, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // SRA
        vecs[3]  = '{32'h00000013, 0, 0, 0, 5'b00010, 2'b00, 1, 4, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // ADDI x0
        vecs[4]  = '{32'hFFF0C213, 0, 0, 0, 5'b01010, 2'b00, 1, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // XORI
        vecs[5]  = '{32'h40315113, 0, 0, 0, 5'b10000, 2'b00, 1, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // SRAI
        vecs[6]  = '{32'h123452B7, 0, 0, 0, 5'b00010, 2'b10, 1, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // LUI
        vecs[7]  = '{32'h00001317, 0, 0, 0, 5'b00010, 2'b01, 1, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // AUIPC
        vecs[8]  = '{32'h0020C463, 0, 0, 0, 5'b00101, 2'b00, 0, 3, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // BLT nt
        vecs[9]  = '{32'h0020E463, 1, 0, 0, 5'b00111, 2'b00, 0, 3, 0, 2'b00, 2'b01, 0, 0, 2'b00, 0}; // BLTU t
        vecs[10] = '{32'h00208463, 1, 0, 0, 5'b00000, 2'b00, 0, 3, 0, 2'b00, 2'b01, 0, 0, 2'b00, 0}; // BEQ t
        vecs[11] = '{32'h0020D463, 0, 0, 0, 5'b00100, 2'b00, 0, 3, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // BGE nt
        vecs[12] = '{32'h0000A283, 0, 0, 3, 5'b00010, 2'b00, 1, 8, 1, 2'b01, 2'b00, 4, 0, 2'b10, 0}; // LW slow
        vecs[13] = '{32'h0020A223, 0, 0, 0, 5'b00010, 2'b00, 1, 4, 0, 2'b00, 2'b00, 1, 1, 2'b10, 0}; // SW
        vecs[14] = '{32'h0000C383, 0, 2, 0, 5'b00010, 2'b00, 1, 7, 1, 2'b01, 2'b00, 1, 0, 2'b00, 1}; // LBU
        vecs[15] = '{32'h010000EF, 0, 0, 0, 5'b00010, 2'b01, 1, 4, 1, 2'b10, 2'b10, 0, 0, 2'b00, 0}; // JAL
        vecs[16] = '{32'h00008067, 0, 0, 0, 5'b00010, 2'b00, 1, 4, 0, 2'b10, 2'b10, 0, 0, 2'b00, 0}; // JALR x0
        vecs[17] = '{32'h0FF0000F, 0, 0, 0, 5'b00010, 2'b00, 0, 3, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // FENCE
        vecs[18] = '{32'h0020B1B3, 0, 0, 0, 5'b01001, 2'b00, 0, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // SLTU
        vecs[19] = '{32'h00109093, 0, 0, 0, 5'b01110, 2'b00, 1, 4, 1, 2'b00, 2'b00, 0, 0, 2'b00, 0}; // SLLI

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst imem_req", imem_req, 0);
        chk("rst ir_write", ir_write, 0);
        chk("rst dmem_req", dmem_req, 0);
        chk("rst reg_write", reg_write, 0);
        chk("rst pc_write", pc_write, 0);
        chk("rst alu_reg_en", alu_reg_en, 0);
        chk("rst alu_op", ALU_op, 5'b00010);
        chk("rst src_a", alu_src_a, 0);
        chk("rst wb_sel", wb_sel, 0);
        chk("rst pc_src", pc_src, 0);
        chk("rst halt", halt, 0);
        chk("rst illegal", illegal, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while a store waits in MEM
        instr = 32'h0020A223;
        zero  = 1'b0;
        got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) got = 1;
        end
        chk("t1 reached mem", got, 1);
        rst_n = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk("t1 pc_write during reset", pc_write, 0);
        @(negedge clk);
        #1;
        chk("t1 dmem_req", dmem_req, 0);
        chk("t1 dmem_we", dmem_we, 0);
        chk("t1 imem_req", imem_req, 0);
        chk("t1 pc_write", pc_write, 0);
        chk("t1 reg_write", reg_write, 0);
        chk("t1 alu_reg_en", alu_reg_en, 0);
        chk("t1 alu_op", ALU_op, 5'b00010);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ready = 1'b0;

        // Illegal opcode parks in TRAP
        instr = 32'h0000007F;
        fetch_once("t6 illegal");
        req_seen = 0;
        pcw_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            imem_ready = imem_req;
            #1;
            if (imem_req) req_seen++;
            if (pc_write) pcw_seen++;
        end
        chk("t6 illegal flag", illegal, 1);
        chk("t6 halt flag", halt, 0);
        chk("t6 imem_req after trap", req_seen, 0);
        chk("t6 pc_write after trap", pcw_seen, 0);

        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t6 illegal cleared", illegal, 0);
        rst_n = 1'b1;

        // ECALL halts
        instr = 32'h00000073;
        fetch_once("t6 ecall");
        req_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            imem_ready = imem_req;
            #1;
            if (imem_req) req_seen++;
        end
        chk("t6 ecall halt", halt, 1);
        chk("t6 ecall illegal", illegal, 0);
        chk("t6 ecall imem_req", req_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
